ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and scan-code decoder. It sits directly upstream of the render top and drives its `keycode` input, which the kid sprite uses for movement and jump.
- Deserialises PS/2 set-2 frames.
- Resolves E0 (extended) and F0 (break) prefixes.
- Presents the currently held key as a stable 8-bit code.

---
 rtl/ps2_keyboard_if.sv | 22 ++
 rtl/ps2_keyboard.sv | 157 +++++++++++++++
 tb/tb_ps2_keyboard.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_if.sv
// Bundles the PS/2 pins and the decoded key outputs of ps2_keyboard.
// master = the receiver/decoder, slave = the keyboard side and the key consumer.
`timescale 1ns/1ps
interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       extended;
    logic       key_valid;
    logic       key_release;
    logic       parity_err;

    modport master (
        input  ps2_clk, ps2_data,
        output keycode, extended, key_valid, key_release, parity_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  keycode, extended, key_valid, key_release, parity_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver: pin conditioning, frame FSM and E0/F0 prefix decoding.
// Define PS2_PARITY_CHECK_EN to reject frames failing the odd-parity check.
`timescale 1ns/1ps
module ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_keyboard_if.master bus
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          fe;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          break_pending, ext_pending;
    logic          parity_ok;

    logic [7:0]    keycode;
    logic          extended, key_valid, key_release, parity_err;

    // NOTE: reset is synchronous, so every register is cleared only inside the clocked branch below.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fe         <= 1'b0;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
            fe     <= 1'b0;
            // The level flips on the FILTER_LEN-th consecutive differing sample.
            if (clk_s2 != filt_level) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_level <= clk_s2;
                    filt_cnt   <= '0;
                    fe         <= filt_level;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    always_ff @(posedge clk) begin
        if (!clrn)
            parity_bit <= 1'b0;
        else if (fe && state == PARITY)
            parity_bit <= dat_s2;
    end
    assign parity_ok = ^{shift, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            tmo_cnt       <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            keycode       <= '0;
            extended      <= 1'b0;
            key_valid     <= 1'b0;
            key_release   <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            parity_err  <= 1'b0;

            if (fe || state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (fe) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: state <= STOP;
                    STOP: begin
                        state <= IDLE;
                        if (!(dat_s2 && parity_ok)) begin
                            parity_err <= 1'b1;
                        end else if (shift == BYTE_EXT) begin
                            ext_pending <= 1'b1;
                        end else if (shift == BYTE_BRK) begin
                            break_pending <= 1'b1;
                        end else begin
                            if (!break_pending) begin
                                keycode   <= shift;
                                extended  <= ext_pending;
                                key_valid <= 1'b1;
                            end else if (shift == keycode && ext_pending == extended) begin
                                keycode     <= '0;
                                extended    <= 1'b0;
                                key_release <= 1'b1;
                            end
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.keycode     = keycode;
    assign bus.extended    = extended;
    assign bus.key_valid   = key_valid;
    assign bus.key_release = key_release;
    assign bus.parity_err  = parity_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed and randomized frames for ps2_keyboard, checked against a byte-level
// model of the prefix/make/break rules; pulses are counted per frame.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int FILT = 8;
    localparam int TMO  = 600;
    localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    ps2_keyboard_if bus ();

    ps2_keyboard #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_kv  = 0;
    int cnt_kr  = 0;
    int cnt_pe  = 0;

    logic [7:0] m_key = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_e0  = 1'b0;
    int         e_kv, e_kr, e_pe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clrn) begin
            cnt_kv += int'(bus.key_valid);
            cnt_kr += int'(bus.key_release);
            cnt_pe += int'(bus.parity_err);
            if (bus.key_valid || bus.key_release || bus.parity_err)
                check("pulse_onehot",
                      32'($countones({bus.key_valid, bus.key_release, bus.parity_err})), 32'd1);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit good_par, input bit stop);
        logic p;
        p = ~^b;
        if (!good_par) p = ~p;
        return {stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = fr[i];
            wait_cycles(HALF);
            bus.ps2_clk = 1'b0;
            wait_cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit valid);
        e_kv = 0; e_kr = 0; e_pe = 0;
        if (!valid) begin
            e_pe = 1;
        end else if (b == 8'hE0) begin
            m_e0 = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                m_key = b; m_ext = m_e0; e_kv = 1;
            end else if (b == m_key && m_e0 == m_ext) begin
                m_key = 8'h00; m_ext = 1'b0; e_kr = 1;
            end
            m_brk = 1'b0; m_e0 = 1'b0;
        end
    endtask

    task automatic clear_counts();
        @(posedge clk);
        cnt_kv = 0; cnt_kr = 0; cnt_pe = 0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_keycode"},     32'(bus.keycode),  32'(m_key));
        check({tag, "_extended"},    32'(bus.extended), 32'(m_ext));
        check({tag, "_key_valid"},   32'(cnt_kv), 32'(e_kv));
        check({tag, "_key_release"}, 32'(cnt_kr), 32'(e_kr));
        check({tag, "_parity_err"},  32'(cnt_pe), 32'(e_pe));
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit good_par, input bit stop);
        clear_counts();
        model_byte(b, stop && (good_par || !PCHK));
        send_bits(make_frame(b, good_par, stop), 11);
        wait_cycles(HALF);
        check_state(tag);
    endtask

    logic [7:0] pool [6] = '{8'h1C, 8'h1D, 8'h23, 8'h74, 8'h6B, 8'h29};

    initial begin
        logic [7:0] b;
        int r;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        clrn = 1'b0;
        wait_cycles(3);
        e_kv = 0; e_kr = 0; e_pe = 0;
        @(negedge clk);
        check("reset_keycode",  32'(bus.keycode),  32'h0);
        check("reset_extended", 32'(bus.extended), 32'h0);
        check("reset_pulses",   32'({bus.key_valid, bus.key_release, bus.parity_err}), 32'h0);
        @(posedge clk);
        clrn = 1'b1;
        wait_cycles(20);

        frame("make_1d", 8'h1D, 1'b1, 1'b1);
        frame("brk_pfx", 8'hF0, 1'b1, 1'b1);
        frame("brk_1d",  8'h1D, 1'b1, 1'b1);
        frame("ext_pfx", 8'hE0, 1'b1, 1'b1);
        frame("make_e74", 8'h74, 1'b1, 1'b1);
        frame("ext_pfx2", 8'hE0, 1'b1, 1'b1);
        frame("brk_pfx2", 8'hF0, 1'b1, 1'b1);
        frame("brk_e74", 8'h74, 1'b1, 1'b1);
        frame("ext_pfx3", 8'hE0, 1'b1, 1'b1);
        frame("make_e74b", 8'h74, 1'b1, 1'b1);
        frame("brk_pfx3", 8'hF0, 1'b1, 1'b1);
        frame("brk_74_noext", 8'h74, 1'b1, 1'b1);
        frame("badpar_1d", 8'h1D, 1'b0, 1'b1);
        frame("repeat_1d", 8'h1D, 1'b1, 1'b1);
        frame("badstop_29", 8'h29, 1'b1, 1'b0);

        // Partial frame then silence: the frame must be dropped without any pulse.
        clear_counts();
        e_kv = 0; e_kr = 0; e_pe = 0;
        send_bits(make_frame(8'h5A, 1'b1, 1'b1), 5);
        wait_cycles(TMO + 10);
        check_state("timeout");
        frame("after_tmo_1c", 8'h1C, 1'b1, 1'b1);

        // Reset in the middle of a frame.
        send_bits(make_frame(8'h6B, 1'b1, 1'b1), 4);
        @(posedge clk);
        clrn = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        check("midrst_keycode",  32'(bus.keycode),  32'h0);
        check("midrst_extended", 32'(bus.extended), 32'h0);
        check("midrst_pulses",   32'({bus.key_valid, bus.key_release, bus.parity_err}), 32'h0);
        @(posedge clk);
        clrn = 1'b1;
        m_key = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_e0 = 1'b0;
        wait_cycles(20);
        frame("after_rst_2b", 8'h2B, 1'b1, 1'b1);

        // Short low glitch on the PS/2 clock with data low looks like a start bit.
        clear_counts();
        e_kv = 0; e_kr = 0; e_pe = 0;
        bus.ps2_data = 1'b0;
        wait_cycles(5);
        bus.ps2_clk = 1'b0;
        wait_cycles(FILT - 2);
        bus.ps2_clk = 1'b1;
        wait_cycles(20);
        bus.ps2_data = 1'b1;
        wait_cycles(5);
        check_state("glitch");
        frame("after_glitch_23", 8'h23, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r < 6 && m_key != 8'h00) b = m_key;
            else            b = pool[$urandom_range(0, 5)];
            frame("rnd", b, ($urandom_range(0, 9) != 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
